parallax_ctrl: RTL and testbench
================================

Name: parallax_ctrl

Overview:
Wishbone-configured controller for the parallax VGA renderer. It holds per-layer scroll speeds, pad output-enables and the run/reset sequencing for the renderer. Speed writes are double-buffered and committed atomically at the next vsync edge, so updates never tear mid-frame. It also keeps a frame counter and raises a vblank interrupt towards user_irq.

Parameters:
- BASE_ADDR, 32'h3000_0000: Wishbone window base; decode on adr[31:8].
- NLAYERS, 4: number of scroll layers (fixed at 4 for register map compatibility).
- SPEED_W, 8: signed speed width per layer.

Ports:
- clk  in  1  system clock (wb_clk_i)
- reset  in  1  synchronous, active-high reset
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- vsync_i  in  1  renderer vsync, active high
- render_reset_o  out  1  reset to renderer
- speed_o  out  NLAYERS*SPEED_W  active (committed) speeds; layer0 in the LSBs
- pad_oeb_o  out  5  oeb for hs, vs, rgb0..2
- frame_o  out  16  frame counter
- irq_o  out  1  vblank interrupt

Behaviour:
- Register map (word offset from BASE_ADDR; reserved bits read 0):
  - 0x00 CTRL: b0 run, b1 irq_en, b2 commit_pending (RO)
  - 0x04 STATUS: b0 irq_pending (W1C), b1 vsync_i level (RO)
  - 0x08 FRAME: [15:0] (RO)
  - 0x0C OEB: [4:0]
  - 0x10, 0x14, 0x18, 0x1C: SPEED0..3 shadow [7:0]
  - 0x20 COMMIT: write b0=1 sets commit_pending
  - 0x24 IRQDIV: optional feature, see below
- Reset values: all registers 0 except OEB = 5'h1F (pads tristated). Outputs: ack 0, dat_o 0, speed_o 0, frame_o 0, irq_o 0, render_reset_o 1.
- Wishbone timing:
  - In-window stb&cyc with ack=0 gives ack=1 on the next cycle for exactly one cycle. This is a single-cycle latency; a held strobe produces ack every other cycle.
  - Write takes effect on the ack cycle edge.
  - dat_o is valid while ack=1 and is 0 otherwise.
  - Out-of-window access: no ack.
  - Unmapped in-window offsets: ack, read 0, write ignored.
- Writes apply only if wbs_sel_i[0]=1; every field sits in byte 0.
- render_reset_o = reset | ~run, registered. The renderer is held in reset until software sets run.
- vsync edge: vsync_i is registered once and edge = vs & ~vs_q. On an edge:
  - If run=1, frame increments and wraps 0xFFFF to 0.
  - If commit_pending=1, all shadow speeds copy to active and pending clears.
  - If irq_en=1, irq_pending is set.
- irq_o = irq_pending & irq_en, registered.
- Simultaneous events:
  - Edge and COMMIT write in the same cycle: transfer uses the pre-write pending value; the write re-arms pending, so set wins.
  - Edge and SPEEDn write in the same cycle: transfer uses the old shadow value.
  - Edge and irq_pending W1C in the same cycle: set wins.
- Reset asserted mid-transaction: ack drops the next cycle and all state returns to reset values.

Optional Feature:
- Macro: PARALLAX_CTRL_IRQ_DIV_EN.
- Enabled: IRQDIV[7:0] = N. An internal counter sets irq_pending only on every (N+1)th edge (N=0 means every frame). The counter resets to 0 on reset or on any IRQDIV write.
- Disabled: IRQDIV reads 0, writes are ignored, and the IRQ fires every frame.

Decomposition:
- Package parallax_ctrl_pkg holds:
  - register offset localparams
  - CTRL/STATUS bit indices
  - OEB_RESET = 5'h1F
  - the speed typedef (logic signed [7:0])
- Sub-module parallax_frame_tick contains the vsync synchroniser/edge detector, the frame counter and the optional IRQ divider. It outputs an edge pulse and a qualified irq_set pulse.

Test Plan:
- Reset, then read all registers: OEB=0x1F, others 0; render_reset_o=1, pad_oeb_o=5'h1F.
- Write CTRL=0x1: render_reset_o falls one cycle after the ack. Pulse vsync 3 times: FRAME=3.
- Write SPEED0=0x7F and SPEED3=0x80, then COMMIT=1: speed_o unchanged and CTRL b2=1. After a vsync edge: speed_o[7:0]=0x7F, speed_o[31:24]=0x80, b2=0.
- With irq_en=1, a vsync edge gives irq_o=1. Write STATUS=1 in the same cycle as the next edge: irq_o stays 1.
- Preload FRAME at 0xFFFF via 65535 edges (or force) and add one more edge: FRAME=0.
- IRQ_DIV_EN build: IRQDIV=2 over 6 edges gives exactly 2 irq_pending sets, on edges 3 and 6. Access at BASE_ADDR+0x100 produces no ack (bench timeout check).

Source files
------------

// File: rtl/parallax_ctrl_pkg.sv
// Shared register map, bit positions and types for the parallax renderer controller.
// The optional IRQ divider is built only when PARALLAX_CTRL_IRQ_DIV_EN is defined.
package parallax_ctrl_pkg;
    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_FRAME  = 8'h08;
    localparam logic [7:0] OFF_OEB    = 8'h0C;
    localparam logic [7:0] OFF_SPEED0 = 8'h10;
    localparam logic [7:0] OFF_SPEED1 = 8'h14;
    localparam logic [7:0] OFF_SPEED2 = 8'h18;
    localparam logic [7:0] OFF_SPEED3 = 8'h1C;
    localparam logic [7:0] OFF_COMMIT = 8'h20;
    localparam logic [7:0] OFF_IRQDIV = 8'h24;

    localparam int CTRL_RUN     = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_PENDING = 2;
    localparam int STAT_IRQ     = 0;
    localparam int STAT_VSYNC   = 1;

    localparam logic [4:0] OEB_RESET = 5'h1F;

    typedef logic signed [7:0] speed_t;
endpackage

// File: rtl/parallax_frame_tick.sv
// Vsync edge detector, frame counter and vblank interrupt qualifier.
// With PARALLAX_CTRL_IRQ_DIV_EN the interrupt fires only on every (N+1)th edge.
module parallax_frame_tick
    import parallax_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync_i,
    input  logic        run_i,
    input  logic        irq_en_i,
    input  logic [7:0]  irq_div_i,
    input  logic        irq_div_wr_i,
    output logic        edge_o,
    output logic        irq_set_o,
    output logic [15:0] frame_o
);
    logic        vs_q, vs_d;
    logic [15:0] frame_q, frame_d;
    logic        div_hit_s;

    // Rising-edge detect against the previous vsync sample; frame count wraps naturally
    always_comb begin
        vs_d      = vsync_i;
        edge_o    = vsync_i & ~vs_q;
        frame_d   = (edge_o && run_i) ? frame_q + 16'd1 : frame_q;
        irq_set_o = edge_o & irq_en_i & div_hit_s;
    end

    // Edge history and frame counter
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_q    <= 1'b0;
            frame_q <= 16'd0;
        end else begin
            vs_q    <= vs_d;
            frame_q <= frame_d;
        end
    end

    assign frame_o = frame_q;

`ifdef PARALLAX_CTRL_IRQ_DIV_EN
    logic [7:0] div_cnt_q, div_cnt_d;

    // Reprogramming the divisor restarts the edge count
    always_comb begin
        div_cnt_d = div_cnt_q;
        div_hit_s = 1'b0;
        if (irq_div_wr_i) begin
            div_cnt_d = 8'd0;
        end else if (edge_o) begin
            if (div_cnt_q >= irq_div_i) begin
                div_hit_s = 1'b1;
                div_cnt_d = 8'd0;
            end else begin
                div_cnt_d = div_cnt_q + 8'd1;
            end
        end else begin
            div_cnt_d = div_cnt_q;
        end
    end

    // Divider edge counter
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= 8'd0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end
`else
    logic unused_div_s;
    assign unused_div_s = ^{irq_div_i, irq_div_wr_i};
    assign div_hit_s    = 1'b1;
`endif
endmodule

// File: rtl/parallax_ctrl.sv
// Wishbone register block for the parallax renderer: speeds committed on vsync, pad OEBs,
// run/reset sequencing, frame counter and vblank IRQ. Optional IRQ divider: PARALLAX_CTRL_IRQ_DIV_EN.
module parallax_ctrl
    import parallax_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NLAYERS   = 4,
    parameter int          SPEED_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wbs_stb_i,
    input  logic                         wbs_cyc_i,
    input  logic                         wbs_we_i,
    input  logic [3:0]                   wbs_sel_i,
    input  logic [31:0]                  wbs_adr_i,
    input  logic [31:0]                  wbs_dat_i,
    output logic                         wbs_ack_o,
    output logic [31:0]                  wbs_dat_o,
    input  logic                         vsync_i,
    output logic                         render_reset_o,
    output logic [NLAYERS*SPEED_W-1:0]   speed_o,
    output logic [4:0]                   pad_oeb_o,
    output logic [15:0]                  frame_o,
    output logic                         irq_o
);
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        run_q, run_d, irq_en_q, irq_en_d, pending_q, pending_d;
    logic        irq_pend_q, irq_pend_d, irq_q, irq_d, rrst_q, rrst_d;
    logic [4:0]  oeb_q, oeb_d;
    speed_t      shadow_q [NLAYERS];
    speed_t      shadow_d [NLAYERS];
    speed_t      active_q [NLAYERS];
    speed_t      active_d [NLAYERS];
    logic        acc_s, wr_s, irq_div_wr_s, edge_s, irq_set_s;
    logic [7:0]  off_s, irq_div_s;
    logic [31:0] rdata_s;
    logic        unused_s;

    assign unused_s = ^{wbs_dat_i[31:8], wbs_sel_i[3:1], wbs_adr_i[1:0]};

`ifdef PARALLAX_CTRL_IRQ_DIV_EN
    logic [7:0] irq_div_q, irq_div_d;

    // Divisor register
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_div_q <= 8'd0;
        end else begin
            irq_div_q <= irq_div_d;
        end
    end

    always_comb begin
        irq_div_d = irq_div_wr_s ? wbs_dat_i[7:0] : irq_div_q;
    end
    assign irq_div_s = irq_div_q;
`else
    assign irq_div_s = 8'd0;
`endif

    parallax_frame_tick u_tick (
        .clk          (clk),
        .reset        (reset),
        .vsync_i      (vsync_i),
        .run_i        (run_q),
        .irq_en_i     (irq_en_q),
        .irq_div_i    (irq_div_s),
        .irq_div_wr_i (irq_div_wr_s),
        .edge_o       (edge_s),
        .irq_set_o    (irq_set_s),
        .frame_o      (frame_o)
    );

    // Bus decode, register updates and vsync-synchronous commit; on collisions the set wins
    always_comb begin
        acc_s        = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
        wr_s         = acc_s & wbs_we_i & wbs_sel_i[0];
        off_s        = {wbs_adr_i[7:2], 2'b00};
        ack_d        = acc_s;
        irq_div_wr_s = 1'b0;
        run_d        = run_q;
        irq_en_d     = irq_en_q;
        pending_d    = pending_q;
        irq_pend_d   = irq_pend_q;
        oeb_d        = oeb_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        if (edge_s && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else begin
            active_d  = active_q;
        end
        if (wr_s) begin
            case (off_s)
                OFF_CTRL: begin
                    run_d    = wbs_dat_i[CTRL_RUN];
                    irq_en_d = wbs_dat_i[CTRL_IRQ_EN];
                end
                OFF_STATUS:  irq_pend_d = irq_pend_q & ~wbs_dat_i[STAT_IRQ];
                OFF_OEB:     oeb_d = wbs_dat_i[4:0];
                OFF_SPEED0, OFF_SPEED1, OFF_SPEED2, OFF_SPEED3:
                             shadow_d[off_s[3:2]] = speed_t'(wbs_dat_i[7:0]);
                OFF_COMMIT:  pending_d = pending_d | wbs_dat_i[0];
                OFF_IRQDIV:  irq_div_wr_s = 1'b1;
                default:     run_d = run_q;
            endcase
        end else begin
            run_d = run_q;
        end
        irq_pend_d = irq_pend_d | irq_set_s;
        rrst_d     = ~run_q;
        irq_d      = irq_pend_q & irq_en_q;
    end

    // Read mux; data is presented only alongside ack
    always_comb begin
        rdata_s = 32'd0;
        case (off_s)
            OFF_CTRL:    rdata_s[2:0] = {pending_q, irq_en_q, run_q};
            OFF_STATUS:  rdata_s[1:0] = {vsync_i, irq_pend_q};
            OFF_FRAME:   rdata_s[15:0] = frame_o;
            OFF_OEB:     rdata_s[4:0] = oeb_q;
            OFF_SPEED0, OFF_SPEED1, OFF_SPEED2, OFF_SPEED3:
                         rdata_s[7:0] = shadow_q[off_s[3:2]];
            OFF_IRQDIV:  rdata_s[7:0] = irq_div_s;
            default:     rdata_s = 32'd0;
        endcase
        dat_d = (acc_s && !wbs_we_i) ? rdata_s : 32'd0;
    end

    // Register state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q      <= 1'b0;
            dat_q      <= 32'd0;
            run_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            pending_q  <= 1'b0;
            irq_pend_q <= 1'b0;
            irq_q      <= 1'b0;
            rrst_q     <= 1'b1;
            oeb_q      <= OEB_RESET;
            shadow_q   <= '{default: 8'sd0};
            active_q   <= '{default: 8'sd0};
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            run_q      <= run_d;
            irq_en_q   <= irq_en_d;
            pending_q  <= pending_d;
            irq_pend_q <= irq_pend_d;
            irq_q      <= irq_d;
            rrst_q     <= rrst_d;
            oeb_q      <= oeb_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
        end
    end

    // Pack committed speeds, layer 0 in the LSBs
    always_comb begin
        speed_o = '0;
        for (int i = 0; i < NLAYERS; i++) begin
            speed_o[i*SPEED_W +: SPEED_W] = active_q[i];
        end
    end

    assign wbs_ack_o      = ack_q;
    assign wbs_dat_o      = dat_q;
    assign render_reset_o = rrst_q;
    assign pad_oeb_o      = oeb_q;
    assign irq_o          = irq_q;
endmodule

// File: tb/tb_parallax_ctrl.sv
// Directed self-checking bench for parallax_ctrl (works with or without PARALLAX_CTRL_IRQ_DIV_EN).
module tb_parallax_ctrl;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        reset, wbs_stb_i, wbs_cyc_i, wbs_we_i, vsync_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
    logic        wbs_ack_o, render_reset_o, irq_o;
    logic [31:0] speed_o;
    logic [4:0]  pad_oeb_o;
    logic [15:0] frame_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_sets;
    int n_acks;
    logic [31:0] rd;
    logic        got;
    logic        exp_set;

    parallax_ctrl dut (
        .clk(clk), .reset(reset), .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i),
        .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .vsync_i(vsync_i), .render_reset_o(render_reset_o), .speed_o(speed_o),
        .pad_oeb_o(pad_oeb_o), .frame_o(frame_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus access, optionally raising vsync on the same cycle; bounded wait for ack
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, input logic with_vs,
                           output logic [31:0] rdat, output logic ack_seen);
        @(negedge clk);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = wdat; wbs_sel_i = sel;
        if (with_vs) vsync_i = 1'b1;
        ack_seen = 1'b0;
        rdat = 32'd0;
        for (int i = 0; i < 8 && !ack_seen; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) begin
                ack_seen = 1'b1;
                rdat = wbs_dat_o;
            end
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        @(negedge clk);
        vsync_i = 1'b0;
    endtask

    task automatic wb_write(input logic [7:0] off, input logic [31:0] d, input logic with_vs);
        logic [31:0] r;
        logic g;
        wb_xfer(1'b1, BASE + {24'd0, off}, d, 4'hF, with_vs, r, g);
        check("write_ack", {31'd0, g}, 32'd1);
    endtask

    task automatic wb_read(input logic [7:0] off, input string tag, input logic [31:0] exp);
        logic [31:0] r;
        logic g;
        wb_xfer(1'b0, BASE + {24'd0, off}, 32'd0, 4'hF, 1'b0, r, g);
        check({tag, "_ack"}, {31'd0, g}, 32'd1);
        check(tag, r, exp);
    endtask

    task automatic vs_pulse();
        @(negedge clk); vsync_i = 1'b1;
        @(negedge clk); vsync_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = 32'd0; wbs_dat_i = 32'd0; vsync_i = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_speed", speed_o, 32'd0);
        check("rst_frame", {16'd0, frame_o}, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        check("rst_rrst", {31'd0, render_reset_o}, 32'd1);
        check("rst_oeb", {27'd0, pad_oeb_o}, 32'h1F);
        wb_read(8'h00, "rd_ctrl0", 32'd0);
        wb_read(8'h04, "rd_status0", 32'd0);
        wb_read(8'h08, "rd_frame0", 32'd0);
        wb_read(8'h0C, "rd_oeb0", 32'h1F);
        wb_read(8'h10, "rd_spd0_0", 32'd0);
        wb_read(8'h1C, "rd_spd3_0", 32'd0);
        wb_read(8'h24, "rd_irqdiv0", 32'd0);
        wb_read(8'h28, "rd_unmapped", 32'd0);

        // Run: renderer reset releases one cycle after the ack
        wb_write(8'h00, 32'h1, 1'b0);
        check("rrst_at_ack", {31'd0, render_reset_o}, 32'd1);
        @(posedge clk); #1;
        check("rrst_released", {31'd0, render_reset_o}, 32'd0);
        repeat (3) vs_pulse();
        wb_read(8'h08, "frame_3", 32'd3);
        check("frame_o_3", {16'd0, frame_o}, 32'd3);

        // Held strobe acks every other cycle
        @(negedge clk);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE; wbs_sel_i = 4'hF;
        n_acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) n_acks++;
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        check("held_stb_acks", n_acks, 32'd2);

        // Pad OEB and byte-select gating
        wb_write(8'h0C, 32'h0A, 1'b0);
        check("oeb_0A", {27'd0, pad_oeb_o}, 32'h0A);
        wb_xfer(1'b1, BASE + 32'h0C, 32'h15, 4'b1110, 1'b0, rd, got);
        check("oeb_sel0_ignored", {27'd0, pad_oeb_o}, 32'h0A);

        // Double-buffered speeds
        wb_write(8'h10, 32'h7F, 1'b0);
        wb_write(8'h1C, 32'h80, 1'b0);
        wb_write(8'h20, 32'h1, 1'b0);
        check("speed_before_edge", speed_o, 32'd0);
        wb_read(8'h00, "ctrl_pending", 32'h5);
        vs_pulse();
        check("speed_committed", speed_o, 32'h8000_007F);
        wb_read(8'h00, "ctrl_pending_clr", 32'h1);

        // Edge with SPEED write uses the old shadow
        wb_write(8'h14, 32'h11, 1'b0);
        wb_write(8'h20, 32'h1, 1'b0);
        wb_write(8'h14, 32'h22, 1'b1);
        check("speed_old_shadow", speed_o, 32'h8000_117F);
        wb_read(8'h00, "ctrl_after_xfer", 32'h1);
        // Edge with COMMIT write: no transfer, pending re-armed
        wb_write(8'h20, 32'h1, 1'b1);
        check("speed_no_xfer", speed_o, 32'h8000_117F);
        wb_read(8'h00, "ctrl_rearmed", 32'h5);
        vs_pulse();
        check("speed_second_commit", speed_o, 32'h8000_227F);
        wb_read(8'h14, "rd_spd1", 32'h22);
        wb_read(8'h1C, "rd_spd3", 32'h80);

        // Vblank IRQ and W1C/set collision
        wb_write(8'h00, 32'h3, 1'b0);
        vs_pulse();
        check("irq_set", {31'd0, irq_o}, 32'd1);
        wb_write(8'h04, 32'h1, 1'b1);
        @(posedge clk); #1;
        check("irq_set_wins", {31'd0, irq_o}, 32'd1);
        wb_read(8'h04, "status_set_wins", 32'h1);
        wb_write(8'h04, 32'h1, 1'b0);
        @(posedge clk); #1;
        check("irq_cleared", {31'd0, irq_o}, 32'd0);
        wb_read(8'h04, "status_cleared", 32'h0);

        // Frame counter wrap
        @(negedge clk);
        force dut.u_tick.frame_q = 16'hFFFF;
        @(negedge clk);
        release dut.u_tick.frame_q;
        wb_read(8'h08, "frame_ffff", 32'hFFFF);
        vs_pulse();
        wb_read(8'h08, "frame_wrap", 32'h0);
        check("frame_o_wrap", {16'd0, frame_o}, 32'd0);
        wb_write(8'h04, 32'h1, 1'b0);

        // IRQ divider (every edge when the feature is absent)
        wb_write(8'h24, 32'h2, 1'b0);
`ifdef PARALLAX_CTRL_IRQ_DIV_EN
        wb_read(8'h24, "rd_irqdiv", 32'h2);
`else
        wb_read(8'h24, "rd_irqdiv", 32'h0);
`endif
        n_sets = 0;
        for (int e = 1; e <= 6; e++) begin
            vs_pulse();
            wb_xfer(1'b0, BASE + 32'h04, 32'd0, 4'hF, 1'b0, rd, got);
`ifdef PARALLAX_CTRL_IRQ_DIV_EN
            exp_set = (e % 3 == 0);
`else
            exp_set = 1'b1;
`endif
            check("div_edge_pending", {31'd0, rd[0]}, {31'd0, exp_set});
            if (rd[0]) n_sets++;
            wb_write(8'h04, 32'h1, 1'b0);
        end
`ifdef PARALLAX_CTRL_IRQ_DIV_EN
        check("div_set_count", n_sets, 32'd2);
`else
        check("div_set_count", n_sets, 32'd6);
`endif

        // Out-of-window access is not acknowledged
        wb_xfer(1'b0, BASE + 32'h100, 32'd0, 4'hF, 1'b0, rd, got);
        check("oow_noack", {31'd0, got}, 32'd0);

        // Reset mid-transaction
        @(negedge clk);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = BASE + 32'h0C; wbs_dat_i = 32'h03; wbs_sel_i = 4'hF;
        @(posedge clk); #1;
        check("midrst_ack_hi", {31'd0, wbs_ack_o}, 32'd1);
        reset = 1'b1;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        @(posedge clk); #1;
        check("midrst_ack_lo", {31'd0, wbs_ack_o}, 32'd0);
        check("midrst_oeb", {27'd0, pad_oeb_o}, 32'h1F);
        check("midrst_speed", speed_o, 32'd0);
        check("midrst_frame", {16'd0, frame_o}, 32'd0);
        check("midrst_rrst", {31'd0, render_reset_o}, 32'd1);
        check("midrst_irq", {31'd0, irq_o}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
